coil_pwm_sequencer: RTL and testbench

- Hysteretic peak/valley current-mode controller that drives the pwm input of the coil current model, running on the same 48 MHz clk.
- Closes the loop on the modelled coil current (iest_coil):
  - switch on until the estimate reaches a peak setpoint;
  - switch off until it falls to a valley setpoint.
- Enforces min on/off and max on times, and latches an overcurrent fault.
- Sits between the launch/charge sequencer (enable, setpoints) and the power stage gate driver and coil model.

---
 rtl/coil_ctrl_pkg.sv | 24 ++
 rtl/coil_phase_timer.sv | 54 +++++
 rtl/coil_pwm_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_coil_pwm_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coil_ctrl_pkg.sv
// coil_ctrl_pkg: shared state type, current-format constants and the
// ADC-code-to-magnitude helper used by the coil PWM sequencer.
package coil_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ON        = 3'd1,
    OFF       = 3'd2,
    OFF_DRAIN = 3'd3,
    FAULT     = 3'd4
  } coil_state_e;

  // ADC code that represents zero coil current; larger current gives a smaller code
  localparam logic [11:0] I_ZERO_CODE = 12'h7FF;

  // Current scaling of all setpoints and estimates
  localparam int unsigned DN_PER_AMP = 205;

  // Convert an ADC-format current code into an unsigned magnitude
  function automatic logic [11:0] adc_to_mag(input logic [11:0] code);
    return code ^ I_ZERO_CODE;
  endfunction

endpackage

// File: rtl/coil_phase_timer.sv
// coil_phase_timer: saturating phase timer for the coil PWM sequencer.
// Clears on request, otherwise counts up and sticks at all-ones.
// Provides terminal compares for the blanking, max-on and min-off limits.
// COIL_PWM_SEQUENCER_STATS_EN additionally exposes the raw count.
module coil_phase_timer
  import coil_ctrl_pkg::*;
#(
  parameter int CNT_W   = 12,
  parameter int MIN_ON  = 8,
  parameter int MAX_ON  = 480,
  parameter int MIN_OFF = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic             min_on_done,
  output logic             max_on_done,
  output logic             min_off_done
`ifdef COIL_PWM_SEQUENCER_STATS_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  localparam logic [CNT_W-1:0] MIN_ON_TC  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MAX_ON_TC  = CNT_W'(MAX_ON - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_TC = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Phase timer: clear on phase entry, count up, saturate instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_r != CNT_MAX) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign min_on_done  = (count_r >= MIN_ON_TC);
  assign max_on_done  = (count_r == MAX_ON_TC);
  assign min_off_done = (count_r >= MIN_OFF_TC);

`ifdef COIL_PWM_SEQUENCER_STATS_EN
  assign count = count_r;
`endif

endmodule

// File: rtl/coil_pwm_sequencer.sv
// coil_pwm_sequencer: hysteretic peak/valley current-mode controller.
// Switches the coil on until the estimated current reaches the peak
// setpoint and off until it decays to the valley setpoint, honouring
// blanking, max-on and min-off limits and latching an overcurrent fault.
// COIL_PWM_SEQUENCER_STATS_EN adds pulse_count and last_on_cycles outputs.
module coil_pwm_sequencer
  import coil_ctrl_pkg::*;
#(
  parameter int MIN_ON  = 8,
  parameter int MAX_ON  = 480,
  parameter int MIN_OFF = 16,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [11:0]      ipeak,
  input  logic [11:0]      ivalley,
  input  logic [11:0]      ifault,
  input  logic [11:0]      iest_coil,
  output logic             pwm,
  output logic             busy,
  output logic             fault,
  output logic             maxon_hit
`ifdef COIL_PWM_SEQUENCER_STATS_EN
  ,
  output logic [15:0]      pulse_count,
  output logic [CNT_W-1:0] last_on_cycles
`endif
);

  coil_state_e state_r;
  coil_state_e state_next_s;

  logic [11:0] i_mag_s;
  logic [11:0] ipeak_r;
  logic [11:0] ivalley_eff_r;
  logic [11:0] ifault_r;
  logic        trip_s;
  logic        start_s;
  logic        maxon_take_s;
  logic        timer_clear_s;
  logic        min_on_done_s;
  logic        max_on_done_s;
  logic        min_off_done_s;
  logic        pwm_next_s;
  logic        busy_next_s;
  logic        fault_next_s;
  logic        pwm_r;
  logic        busy_r;
  logic        fault_r;
  logic        maxon_hit_r;
`ifdef COIL_PWM_SEQUENCER_STATS_EN
  logic [CNT_W-1:0] timer_s;
  logic [15:0]      pulse_count_r;
  logic [CNT_W-1:0] last_on_cycles_r;
`endif

  assign i_mag_s = adc_to_mag(iest_coil);
  assign trip_s  = (i_mag_s >= ifault_r);
  assign start_s = (state_r == IDLE) && (state_next_s == ON);

  // Timer restarts on every phase change and is held at zero while parked
  assign timer_clear_s = (state_next_s != state_r) || (state_next_s == IDLE) ||
                         (state_next_s == FAULT);

  coil_phase_timer #(
    .CNT_W   (CNT_W),
    .MIN_ON  (MIN_ON),
    .MAX_ON  (MAX_ON),
    .MIN_OFF (MIN_OFF)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .clear        (timer_clear_s),
    .min_on_done  (min_on_done_s),
    .max_on_done  (max_on_done_s),
    .min_off_done (min_off_done_s)
`ifdef COIL_PWM_SEQUENCER_STATS_EN
    ,
    .count        (timer_s)
`endif
  );

  // Capture setpoints at run start; an inverted window falls back to half the peak
  always_ff @(posedge clk) begin
    if (reset) begin
      ipeak_r       <= 12'h000;
      ivalley_eff_r <= 12'h000;
      ifault_r      <= 12'h000;
    end else if (start_s) begin
      ipeak_r       <= ipeak;
      ivalley_eff_r <= (ivalley >= ipeak) ? (ipeak >> 1) : ivalley;
      ifault_r      <= ifault;
    end else begin
      ipeak_r       <= ipeak_r;
      ivalley_eff_r <= ivalley_eff_r;
      ifault_r      <= ifault_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: overcurrent first, then enable loss, then regulation
  always_comb begin
    state_next_s = state_r;
    maxon_take_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = ON;
        end else begin
          state_next_s = IDLE;
        end
      end
      ON: begin
        if (trip_s) begin
          state_next_s = FAULT;
        end else if (!enable) begin
          state_next_s = OFF_DRAIN;
        end else if (max_on_done_s) begin
          state_next_s = OFF;
          maxon_take_s = 1'b1;
        end else if (min_on_done_s && (i_mag_s >= ipeak_r)) begin
          state_next_s = OFF;
        end else begin
          state_next_s = ON;
        end
      end
      OFF: begin
        if (trip_s) begin
          state_next_s = FAULT;
        end else if (!enable) begin
          state_next_s = OFF_DRAIN;
        end else if (min_off_done_s && (i_mag_s <= ivalley_eff_r)) begin
          state_next_s = ON;
        end else begin
          state_next_s = OFF;
        end
      end
      OFF_DRAIN: begin
        if (trip_s) begin
          state_next_s = FAULT;
        end else if (min_off_done_s && (i_mag_s == 12'h000)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OFF_DRAIN;
        end
      end
      FAULT: begin
        if (!enable) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FAULT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state so registered outputs line up with it
  always_comb begin
    pwm_next_s   = 1'b0;
    busy_next_s  = 1'b0;
    fault_next_s = 1'b0;
    case (state_next_s)
      ON: begin
        pwm_next_s  = 1'b1;
        busy_next_s = 1'b1;
      end
      OFF, OFF_DRAIN: begin
        busy_next_s = 1'b1;
      end
      FAULT: begin
        fault_next_s = 1'b1;
      end
      default: begin
        pwm_next_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_r       <= 1'b0;
      busy_r      <= 1'b0;
      fault_r     <= 1'b0;
      maxon_hit_r <= 1'b0;
    end else begin
      pwm_r       <= pwm_next_s;
      busy_r      <= busy_next_s;
      fault_r     <= fault_next_s;
      maxon_hit_r <= maxon_take_s;
    end
  end

  assign pwm       = pwm_r;
  assign busy      = busy_r;
  assign fault     = fault_r;
  assign maxon_hit = maxon_hit_r;

`ifdef COIL_PWM_SEQUENCER_STATS_EN
  // Count on-pulses per run and record the length of every on-phase
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_count_r    <= 16'h0000;
      last_on_cycles_r <= {CNT_W{1'b0}};
    end else begin
      if (start_s) begin
        pulse_count_r <= 16'h0001;
      end else if ((state_r == OFF) && (state_next_s == ON) &&
                   (pulse_count_r != 16'hFFFF)) begin
        pulse_count_r <= pulse_count_r + 16'h0001;
      end else begin
        pulse_count_r <= pulse_count_r;
      end
      if ((state_r == ON) && (state_next_s != ON)) begin
        last_on_cycles_r <= timer_s;
      end else begin
        last_on_cycles_r <= last_on_cycles_r;
      end
    end
  end

  assign pulse_count    = pulse_count_r;
  assign last_on_cycles = last_on_cycles_r;
`endif

endmodule

// File: tb/tb_coil_pwm_sequencer.sv
// tb_coil_pwm_sequencer: randomized closed-loop bench for coil_pwm_sequencer
// with a behavioural reference model and a simple coil current ramp model.
module tb_coil_pwm_sequencer;

  localparam int MIN_ON  = 8;
  localparam int MAX_ON  = 480;
  localparam int MIN_OFF = 16;
  localparam int CNT_W   = 12;
  localparam int DN      = coil_ctrl_pkg::DN_PER_AMP;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] ipeak;
  logic [11:0] ivalley;
  logic [11:0] ifault;
  logic [11:0] iest_coil;
  logic        pwm;
  logic        busy;
  logic        fault;
  logic        maxon_hit;
`ifdef COIL_PWM_SEQUENCER_STATS_EN
  logic [15:0]      pulse_count;
  logic [CNT_W-1:0] last_on_cycles;
`endif

  always #5 clk = ~clk;

  coil_pwm_sequencer #(
    .MIN_ON  (MIN_ON),
    .MAX_ON  (MAX_ON),
    .MIN_OFF (MIN_OFF),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .ipeak          (ipeak),
    .ivalley        (ivalley),
    .ifault         (ifault),
    .iest_coil      (iest_coil),
    .pwm            (pwm),
    .busy           (busy),
    .fault          (fault),
    .maxon_hit      (maxon_hit)
`ifdef COIL_PWM_SEQUENCER_STATS_EN
    ,
    .pulse_count    (pulse_count),
    .last_on_cycles (last_on_cycles)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase name plus cycles spent in it, from the behavioural rules
  localparam int M_IDLE = 0, M_ON = 1, M_OFF = 2, M_DRAIN = 3, M_FAULT = 4;
  int m_phase = M_IDLE;
  int m_age = 0;
  int sp_peak = 0, sp_valley = 0, sp_fault = 0;
  bit e_pwm = 0, e_busy = 0, e_fault = 0, e_mx = 0;
  int e_pulses = 0, e_last_on = 0;

  task automatic model_step();
    int mag;
    int nxt;
    bit mx;
    mag = int'(iest_coil ^ 12'h7FF);
    mx  = 1'b0;
    nxt = m_phase;
    if (reset) begin
      m_phase = M_IDLE; m_age = 0; e_pulses = 0; e_last_on = 0;
      sp_peak = 0; sp_valley = 0; sp_fault = 0;
    end else begin
      if (m_phase == M_IDLE) begin
        if (enable) begin
          nxt = M_ON;
          sp_peak  = int'(ipeak);
          sp_fault = int'(ifault);
          sp_valley = (int'(ivalley) >= int'(ipeak)) ? int'(ipeak) / 2 : int'(ivalley);
        end
      end else if (m_phase == M_FAULT) begin
        if (!enable) nxt = M_IDLE;
      end else if (mag >= sp_fault) begin
        nxt = M_FAULT;
      end else if (!enable && m_phase != M_DRAIN) begin
        nxt = M_DRAIN;
      end else if (m_phase == M_ON) begin
        if (m_age == MAX_ON - 1) begin
          nxt = M_OFF; mx = 1'b1;
        end else if (m_age >= MIN_ON - 1 && mag >= sp_peak) begin
          nxt = M_OFF;
        end
      end else if (m_phase == M_OFF) begin
        if (m_age >= MIN_OFF - 1 && mag <= sp_valley) nxt = M_ON;
      end else begin
        if (m_age >= MIN_OFF - 1 && mag == 0) nxt = M_IDLE;
      end
      if (m_phase == M_ON && nxt != M_ON) e_last_on = m_age;
      if (nxt == M_ON && m_phase == M_IDLE) e_pulses = 1;
      else if (nxt == M_ON && m_phase == M_OFF && e_pulses < 65535) e_pulses++;
      m_age   = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase = nxt;
    end
    e_pwm   = (m_phase == M_ON);
    e_busy  = (m_phase == M_ON || m_phase == M_OFF || m_phase == M_DRAIN);
    e_fault = (m_phase == M_FAULT);
    e_mx    = mx;
  endtask

  // Coil model: linear ramp up while pwm is high, down while low
  int coil_i = 0;
  int up = 5, down = 2;
  bit pin_on = 1'b1;
  logic [11:0] pin_code = 12'h7FF;

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pwm", 32'(pwm), 32'(e_pwm));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("fault", 32'(fault), 32'(e_fault));
    chk("maxon_hit", 32'(maxon_hit), 32'(e_mx));
`ifdef COIL_PWM_SEQUENCER_STATS_EN
    chk("pulse_count", 32'(pulse_count), 32'(e_pulses));
    chk("last_on", 32'(last_on_cycles), 32'(e_last_on));
`endif
    if (pwm) coil_i += up; else coil_i -= down;
    if (coil_i < 0) coil_i = 0;
    if (coil_i > 4095) coil_i = 4095;
    if (pin_on) iest_coil = pin_code; else iest_coil = 12'h7FF ^ 12'(coil_i);
  endtask

  task automatic pin(input int mag);
    pin_on = 1'b1;
    pin_code = 12'h7FF ^ 12'(mag);
    iest_coil = pin_code;
  endtask

  task automatic close_loop();
    pin_on = 1'b0;
    coil_i = 0;
    iest_coil = 12'h7FF;
  endtask

  task automatic drain_to_idle();
    enable = 1'b0;
    pin(0);
    for (int k = 0; k < 100 && (busy || fault); k++) tick();
    chk("idle_reached", 32'(busy | fault), 32'd0);
  endtask

  int toggles, max_mag, min_mag, mx_cnt, flt_cnt, hi, lo, n;
  bit prev, seen_peak;

  initial begin
    reset = 1'b1; enable = 1'b0;
    ipeak = 12'h000; ivalley = 12'h000; ifault = 12'hFFF;
    iest_coil = 12'h7FF;
    repeat (3) tick();
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_maxon", 32'(maxon_hit), 32'd0);
    reset = 1'b0;
    tick();

    // Normal closed-loop regulation at 5 A / 3 A
    up = $urandom_range(4, 8); down = $urandom_range(2, 4);
    ipeak = 12'(5 * DN); ivalley = 12'(3 * DN); ifault = 12'd4000;
    close_loop();
    enable = 1'b1;
    toggles = 0; max_mag = 0; min_mag = 4095; mx_cnt = 0; flt_cnt = 0;
    seen_peak = 1'b0; prev = 1'b0;
    repeat (3000) begin
      tick();
      if (pwm != prev) toggles++;
      prev = pwm;
      if (coil_i >= 5 * DN) seen_peak = 1'b1;
      if (seen_peak) begin
        if (coil_i > max_mag) max_mag = coil_i;
        if (coil_i < min_mag) min_mag = coil_i;
      end
      if (maxon_hit) mx_cnt++;
      if (fault) flt_cnt++;
    end
    chk("reg_toggles", 32'(toggles >= 6), 32'd1);
    chk("reg_peak", 32'(max_mag <= 5 * DN + 2 * up), 32'd1);
    chk("reg_valley", 32'(min_mag >= 3 * DN - 2 * down), 32'd1);
    chk("reg_maxon", 32'(mx_cnt), 32'd0);
    chk("reg_fault", 32'(flt_cnt), 32'd0);
    drain_to_idle();

    // Max-on: current never rises
    pin(0);
    ipeak = 12'(5 * DN); ivalley = 12'(3 * DN); ifault = 12'd4000;
    enable = 1'b1;
    tick();
    chk("maxon_start", 32'(pwm), 32'd1);
    hi = 1; mx_cnt = 0;
    while (hi < 1000) begin
      tick();
      if (maxon_hit) mx_cnt++;
      if (!pwm) break;
      hi++;
    end
    chk("maxon_len", 32'(hi), 32'd480);
    lo = 1;
    while (lo < 100) begin
      tick();
      if (maxon_hit) mx_cnt++;
      if (pwm) break;
      lo++;
    end
    chk("maxon_off", 32'(lo), 32'd16);
    chk("maxon_pulses", 32'(mx_cnt), 32'd1);
    drain_to_idle();

    // Overcurrent trip during ON
    ipeak = 12'(5 * DN); ivalley = 12'(3 * DN); ifault = 12'd2000;
    close_loop();
    enable = 1'b1;
    repeat ($urandom_range(2, 100)) tick();
    chk("flt_pre_on", 32'(pwm), 32'd1);
    pin(2001);
    tick();
    chk("flt_pwm", 32'(pwm), 32'd0);
    chk("flt_set", 32'(fault), 32'd1);
    pin(0);
    repeat ($urandom_range(3, 20)) tick();
    chk("flt_hold", 32'(fault), 32'd1);
    enable = 1'b0;
    tick();
    chk("flt_clear", 32'(fault), 32'd0);
    chk("flt_busy", 32'(busy), 32'd0);

    // Enable drop mid-ON
    ipeak = 12'(5 * DN); ivalley = 12'(3 * DN); ifault = 12'd4000;
    close_loop();
    enable = 1'b1;
    repeat ($urandom_range(10, 100)) tick();
    chk("drop_on", 32'(pwm), 32'd1);
    enable = 1'b0;
    pin(0);
    tick();
    chk("drop_pwm", 32'(pwm), 32'd0);
    chk("drop_busy", 32'(busy), 32'd1);
    n = 1;
    while (n < 100) begin
      tick();
      if (!busy) break;
      n++;
    end
    chk("drop_len", 32'(n), 32'd16);

    // Inverted setpoints: valley falls back to ipeak/2 = 500
    ipeak = 12'd1000; ivalley = 12'd1100; ifault = 12'd4000;
    pin(1000);
    enable = 1'b1;
    repeat (12) tick();
    chk("bad_off", 32'(pwm), 32'd0);
    pin(501);
    repeat (30) tick();
    chk("bad_hold", 32'(pwm), 32'd0);
    pin(500);
    tick();
    chk("bad_on", 32'(pwm), 32'd1);
    drain_to_idle();

    // Reset mid-ON, then restart
    ipeak = 12'(5 * DN); ivalley = 12'(3 * DN); ifault = 12'd4000;
    close_loop();
    enable = 1'b1;
    repeat ($urandom_range(5, 50)) tick();
    reset = 1'b1;
    tick();
    chk("rstmid_pwm", 32'(pwm), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_restart", 32'(pwm), 32'd1);
    drain_to_idle();

    // Random mix of setpoints, enable toggles, resets and current glitches
    close_loop();
    enable = 1'b1;
    repeat (4000) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      reset   = ($urandom_range(0, 599) == 0);
      ipeak   = 12'($urandom_range(200, 1500));
      ivalley = 12'($urandom_range(0, 1500));
      ifault  = 12'($urandom_range(1200, 4095));
      if ($urandom_range(0, 99) == 0) begin
        pin_on = 1'b1;
        pin_code = 12'($urandom);
        iest_coil = pin_code;
      end else begin
        pin_on = 1'b0;
        iest_coil = 12'h7FF ^ 12'(coil_i);
      end
      tick();
    end
    reset = 1'b0;
    drain_to_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
